reg_dump_ctrl: RTL and testbench
================================

// Module: reg_dump_ctrl
// PURPOSE
//  Hardware counterpart of the simulation register monitor: watches the CPU PC and freezes the core at a breakpoint.
//  Sweeps the reg_sel/reg_data debug port over x0..x31 and streams a framed byte record (PC, instr, 32 regs) out.
//  Output goes over a valid/ready byte link, e.g. to a UART TX.
//  Sits beside sccomp at board top; on cycle-budget exhaustion it streams a timeout record instead.
// PARAMETERS
//  BP_ADDR     32'h0000_0048  breakpoint PC; match halts core and triggers dump
//  MAX_CYCLES  2000           run-cycle budget before timeout record
//  NREGS       32             registers swept (x0..x(NREGS-1)); fixed 32 in this design
// PORTS
//  clk        in   1   system clock, rising edge
//  rst        in   1   synchronous, active-high reset
//  arm        in   1   1-cycle pulse: start monitoring (IDLE->RUN); ignored in other states
//  pc_in      in   32  current CPU PC
//  instr_in   in   32  instruction at pc_in
//  cpu_halt   out  1   freezes CPU PC/pipeline while high
//  reg_sel    out  5   register-file debug read select
//  reg_data   in   32  rf[reg_sel], combinational from core
//  tx_data    out  8   record byte
//  tx_valid   out  1   tx_data valid
//  tx_ready   in   1   sink accepts byte on clk edge where tx_valid&&tx_ready
//  done       out  1   level: record fully sent (breakpoint or timeout)
//  timeout    out  1   level: record was a timeout record
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; cycle counter 0; checksum 0. Reset mid-record aborts it; no partial resume.
//  States: IDLE -> RUN -> (HIT | TMO) -> SEL -> CAP -> SEND ... -> TRL -> DONE.
//   IDLE: wait arm.
//   RUN: counter+1 per cycle.
//    - pc_in==BP_ADDR: latch pc/instr, cpu_halt=1 next cycle, -> HIT.
//    - else counter==MAX_CYCLES-1: latch pc, -> TMO.
//    - Match and budget in the same cycle: breakpoint wins.
//   HIT: emit header 0xA5, PC[31:24]..PC[7:0], instr big-endian (9 bytes), then reg sweep.
//   Sweep per reg i: SEL drives reg_sel=i; CAP samples reg_data one cycle later; SEND emits 4 bytes big-endian.
//    - x0 always sent as 0x00000000 regardless of reg_data.
//   TMO: emit header 0x5A, PC (4B), counter value (4B); no sweep; timeout=1.
//   TRL: emit checksum = XOR of every byte after the header; then DONE.
//   DONE: done=1, cpu_halt stays 1 (breakpoint case) until rst.
//  Record lengths: breakpoint 1+8+128+1 = 138 bytes; timeout 1+8+1 = 10 bytes.
//  Handshake: tx_data stable and tx_valid held until accepted; no byte drop or dup; tx_valid may fall only after accept.
//   Back-to-back bytes allowed (1 byte/cycle when tx_ready held high).
//  Sweep cost: 2 cycles per reg plus 4 byte transfers. reg_sel holds value until its 4th byte is accepted.
//  Counter: 32-bit, saturates, never wraps; reg index wraps never (stop after 31).
//  cpu_halt asserted exactly 1 cycle after match; core PC must not advance after that edge.
// STRUCTURE
//  Package dump_pkg: state enum, HDR_BP=8'hA5, HDR_TMO=8'h5A, record lengths, byte-index widths.
//  Sub-module dump_byte_tx: loads a 32-bit word, shifts out 4 bytes MSB-first over valid/ready.
//   Reports word_done; carries the running XOR checksum.
//  reg_dump_ctrl keeps FSM, counter, latches, reg index.
// TESTING
//  1 Program reaching PC=0x48 at cycle 30, tx_ready=1, x5=0x12345678:
//    halt at cycle 31; 138 bytes; byte0=A5; x5 bytes 12 34 56 78; checksum matches; done=1.
//  2 Same with tx_ready random 30% duty: byte stream identical to case 1; tx_data stable while stalled.
//  3 Infinite loop never reaching BP, MAX_CYCLES=2000:
//    timeout=1; 10 bytes 5A, PC, 00 00 07 D0, chk; cpu_halt=0.
//  4 Force rf[0] reg_data=0xFFFFFFFF on reg_sel=0 -> x0 bytes 00 00 00 00.
//  5 PC hits BP on the same cycle counter reaches MAX_CYCLES-1 -> breakpoint record, timeout=0.
//  6 rst pulsed at byte 60 -> next cycle tx_valid=0, cpu_halt=0, IDLE; fresh arm gives full correct record.

Source files
------------

// File: rtl/reg_dump_ctrl_pkg.sv
// Shared types and constants for the breakpoint register-dump controller.
// Record framing: header byte, PC, instr or cycle count, optional reg sweep, XOR trailer.
package reg_dump_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RUN,
    ST_HIT,
    ST_TMO,
    ST_PC,
    ST_INS,
    ST_CNT,
    ST_SEL,
    ST_CAP,
    ST_SEND,
    ST_TRL,
    ST_DONE
  } state_t;

  localparam logic [7:0] HDR_BP      = 8'hA5;
  localparam logic [7:0] HDR_TMO     = 8'h5A;
  localparam int         REC_LEN_BP  = 138;
  localparam int         REC_LEN_TMO = 10;
  localparam int         BYTE_IDX_W  = 8;

  // Places a single byte where the byte shifter sends first.
  function automatic logic [31:0] byte_word(input logic [7:0] b);
    return {b, 24'h00_0000};
  endfunction

endpackage

// File: rtl/reg_dump_ctrl_if.sv
// Valid/ready byte link carrying the dump record, e.g. towards a UART TX.
interface reg_dump_ctrl_if;
  import reg_dump_ctrl_pkg::*;

  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/reg_dump_ctrl_byte_tx.sv
// Shifts a loaded word out MSB-first over valid/ready (1 or 4 bytes) and keeps the
// running XOR of checksummed bytes; a load may coincide with the last byte's accept.
module reg_dump_ctrl_byte_tx
  import reg_dump_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic        i_load_chk,
  input  logic [2:0]  i_len,
  input  logic [31:0] i_word,
  input  logic        i_chk_en,
  input  logic        i_chk_clr,
  input  logic        i_tx_ready,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  output logic        o_word_done
);

  logic [31:0] r_shift;
  logic [2:0]  r_left;
  logic        r_valid;
  logic        r_chk_en;
  logic [7:0]  r_chk;

  logic        w_accept;
  logic        w_last;
  logic [7:0]  w_chk_next;
  logic [31:0] w_word;

  // The trailer is loaded with the checksum including the byte accepted this very cycle.
  always_comb begin
    w_accept = r_valid & i_tx_ready;
    w_last   = w_accept & (r_left == 3'd1);
    if (w_accept && r_chk_en) begin
      w_chk_next = r_chk ^ r_shift[31:24];
    end else begin
      w_chk_next = r_chk;
    end
    if (i_load_chk) begin
      w_word = byte_word(w_chk_next);
    end else begin
      w_word = i_word;
    end
  end

  // Shift register, byte counter, valid flag and checksum.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift  <= 32'h0000_0000;
      r_left   <= 3'd0;
      r_valid  <= 1'b0;
      r_chk_en <= 1'b0;
      r_chk    <= 8'h00;
    end else begin
      r_chk <= i_chk_clr ? 8'h00 : w_chk_next;
      if (i_load) begin
        r_shift  <= w_word;
        r_left   <= i_len;
        r_valid  <= 1'b1;
        r_chk_en <= i_chk_en;
      end else if (w_accept) begin
        r_shift <= {r_shift[23:0], 8'h00};
        r_left  <= r_left - 3'd1;
        r_valid <= ~w_last;
      end
    end
  end

  assign o_tx_data   = r_shift[31:24];
  assign o_tx_valid  = r_valid;
  assign o_word_done = w_last;

endmodule

// File: rtl/reg_dump_ctrl.sv
// Watches the CPU PC, halts the core at a breakpoint and streams a framed register
// dump (or a timeout record once the cycle budget runs out) over a byte link.
module reg_dump_ctrl
  import reg_dump_ctrl_pkg::*;
#(
  parameter logic [31:0] BP_ADDR    = 32'h0000_0048,
  parameter int          MAX_CYCLES = 2000,
  parameter int          NREGS      = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_arm,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_instr,
  output logic        o_cpu_halt,
  output logic [4:0]  o_reg_sel,
  input  logic [31:0] i_reg_data,
  output logic        o_done,
  output logic        o_timeout,
  reg_dump_ctrl_if.master tx
);

  localparam logic [31:0] LAST_CYCLE = 32'(MAX_CYCLES - 1);
  localparam logic [4:0]  LAST_REG   = 5'(NREGS - 1);

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_cycles;
  logic [4:0]  r_idx;
  logic        r_halt;
  logic        r_done;
  logic        r_timeout;

  logic        w_load;
  logic        w_load_chk;
  logic [2:0]  w_len;
  logic [31:0] w_word;
  logic        w_chk_en;
  logic        w_chk_clr;
  logic        w_arm;
  logic        w_latch_bp;
  logic        w_latch_tmo;
  logic        w_idx_inc;
  logic        w_set_done;
  logic        w_word_done;

  reg_dump_ctrl_byte_tx u_byte_tx (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_load),
    .i_load_chk  (w_load_chk),
    .i_len       (w_len),
    .i_word      (w_word),
    .i_chk_en    (w_chk_en),
    .i_chk_clr   (w_chk_clr),
    .i_tx_ready  (tx.tx_ready),
    .o_tx_data   (tx.tx_data),
    .o_tx_valid  (tx.tx_valid),
    .o_word_done (w_word_done)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and per-cycle strobes; each word is loaded as the previous one finishes.
  always_comb begin
    w_next      = r_state;
    w_load      = 1'b0;
    w_load_chk  = 1'b0;
    w_len       = 3'd4;
    w_word      = 32'h0000_0000;
    w_chk_en    = 1'b1;
    w_chk_clr   = 1'b0;
    w_arm       = 1'b0;
    w_latch_bp  = 1'b0;
    w_latch_tmo = 1'b0;
    w_idx_inc   = 1'b0;
    w_set_done  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_arm) begin
          w_arm  = 1'b1;
          w_next = ST_RUN;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_RUN: begin
        // Breakpoint takes priority over an expiring budget in the same cycle.
        if (i_pc == BP_ADDR) begin
          w_latch_bp = 1'b1;
          w_load     = 1'b1;
          w_len      = 3'd1;
          w_word     = byte_word(HDR_BP);
          w_chk_en   = 1'b0;
          w_chk_clr  = 1'b1;
          w_next     = ST_HIT;
        end else if (r_cycles == LAST_CYCLE) begin
          w_latch_tmo = 1'b1;
          w_load      = 1'b1;
          w_len       = 3'd1;
          w_word      = byte_word(HDR_TMO);
          w_chk_en    = 1'b0;
          w_chk_clr   = 1'b1;
          w_next      = ST_TMO;
        end else begin
          w_next = ST_RUN;
        end
      end
      ST_HIT, ST_TMO: begin
        if (w_word_done) begin
          w_load = 1'b1;
          w_word = r_pc;
          w_next = ST_PC;
        end else begin
          w_next = r_state;
        end
      end
      ST_PC: begin
        if (w_word_done) begin
          w_load = 1'b1;
          w_word = r_timeout ? r_cycles : r_instr;
          w_next = r_timeout ? ST_CNT : ST_INS;
        end else begin
          w_next = ST_PC;
        end
      end
      ST_INS: begin
        if (w_word_done) begin
          w_next = ST_SEL;
        end else begin
          w_next = ST_INS;
        end
      end
      ST_SEL: begin
        w_next = ST_CAP;
      end
      ST_CAP: begin
        w_load = 1'b1;
        w_word = (r_idx == 5'd0) ? 32'h0000_0000 : i_reg_data;
        w_next = ST_SEND;
      end
      ST_SEND: begin
        if (w_word_done && (r_idx == LAST_REG)) begin
          w_load     = 1'b1;
          w_load_chk = 1'b1;
          w_len      = 3'd1;
          w_chk_en   = 1'b0;
          w_next     = ST_TRL;
        end else if (w_word_done) begin
          w_idx_inc = 1'b1;
          w_next    = ST_SEL;
        end else begin
          w_next = ST_SEND;
        end
      end
      ST_CNT: begin
        if (w_word_done) begin
          w_load     = 1'b1;
          w_load_chk = 1'b1;
          w_len      = 3'd1;
          w_chk_en   = 1'b0;
          w_next     = ST_TRL;
        end else begin
          w_next = ST_CNT;
        end
      end
      ST_TRL: begin
        if (w_word_done) begin
          w_set_done = 1'b1;
          w_next     = ST_DONE;
        end else begin
          w_next = ST_TRL;
        end
      end
      ST_DONE: begin
        w_next = ST_DONE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Cycle budget, latched PC/instr, sweep index and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc      <= 32'h0000_0000;
      r_instr   <= 32'h0000_0000;
      r_cycles  <= 32'h0000_0000;
      r_idx     <= 5'd0;
      r_halt    <= 1'b0;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      if (w_arm) begin
        r_cycles <= 32'h0000_0000;
      end else if ((r_state == ST_RUN) && (r_cycles != 32'hFFFF_FFFF)) begin
        r_cycles <= r_cycles + 32'd1;
      end
      if (w_latch_bp) begin
        r_pc    <= i_pc;
        r_instr <= i_instr;
        r_halt  <= 1'b1;
      end
      if (w_latch_tmo) begin
        r_pc      <= i_pc;
        r_timeout <= 1'b1;
      end
      if (w_idx_inc) begin
        r_idx <= r_idx + 5'd1;
      end
      if (w_set_done) begin
        r_done <= 1'b1;
      end
    end
  end

  assign o_cpu_halt = r_halt;
  assign o_reg_sel  = r_idx;
  assign o_done     = r_done;
  assign o_timeout  = r_timeout;

endmodule

// File: tb/tb_reg_dump_ctrl.sv
// Randomized bench: a record model fills an expected-byte queue at arm time and a
// negedge monitor checks every accepted byte plus stall stability.
module tb_reg_dump_ctrl;
  import reg_dump_ctrl_pkg::*;

  localparam logic [31:0] BP  = 32'h0000_0048;
  localparam int          MAX = 2000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_arm = 1'b0;
  logic [31:0] pc = 32'h0;
  logic [31:0] instr = 32'h0;
  logic        cpu_halt;
  logic [4:0]  reg_sel;
  logic [31:0] reg_data;
  logic        done;
  logic        timeout;
  logic [31:0] rf [32];

  int checks = 0;
  int errors = 0;
  int rx_count = 0;
  int ready_pct = 100;
  int bp_k = -1;
  int run_k = 0;
  bit running = 1'b0;
  bit prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic [7:0] exp_q[$];

  reg_dump_ctrl_if u_if ();

  reg_dump_ctrl #(.BP_ADDR(BP), .MAX_CYCLES(MAX), .NREGS(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_arm      (i_arm),
    .i_pc       (pc),
    .i_instr    (instr),
    .o_cpu_halt (cpu_halt),
    .o_reg_sel  (reg_sel),
    .i_reg_data (reg_data),
    .o_done     (done),
    .o_timeout  (timeout),
    .tx         (u_if)
  );

  always #5 clk = ~clk;

  always_comb reg_data = rf[reg_sel];

  function automatic logic [31:0] prog_pc(input int k, input int bp);
    if (k == bp) return BP;
    return 32'h0000_0100 + 32'(4 * (k % 16));
  endfunction

  function automatic logic [31:0] instr_of(input logic [31:0] p);
    return {p[15:0], 16'h0013} ^ 32'h1234_0000;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive_pc();
    pc = prog_pc(run_k, bp_k);
    instr = instr_of(pc);
    run_k++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    u_if.tx_ready = ($urandom_range(0, 99) < ready_pct);
    if (running && !cpu_halt) drive_pc();
  endtask

  // Record model: header, PC, instr or cycle count, regs (x0 reads as zero), XOR of body.
  task automatic push_record(input bit tmo, input logic [31:0] pc_v, input logic [31:0] second);
    logic [7:0] body[$];
    logic [31:0] w;
    logic [7:0] x;
    body = {};
    for (int b = 3; b >= 0; b--) body.push_back(pc_v[8*b +: 8]);
    for (int b = 3; b >= 0; b--) body.push_back(second[8*b +: 8]);
    if (!tmo) begin
      for (int r = 0; r < 32; r++) begin
        w = (r == 0) ? 32'h0 : rf[r];
        for (int b = 3; b >= 0; b--) body.push_back(w[8*b +: 8]);
      end
    end
    x = 8'h00;
    foreach (body[i]) x = x ^ body[i];
    exp_q.push_back(tmo ? 8'h5A : 8'hA5);
    foreach (body[i]) exp_q.push_back(body[i]);
    exp_q.push_back(x);
  endtask

  // Scoreboard monitor: a byte shown with valid&&ready at negedge is taken at the next edge.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (!(u_if.tx_valid && u_if.tx_data == prev_data)) begin
          errors++;
          $display("FAIL stall_hold: got valid=%b data=%h expected valid=1 data=%h",
                   u_if.tx_valid, u_if.tx_data, prev_data);
        end
      end
      if (u_if.tx_valid && u_if.tx_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL tx_byte[%0d]: got %h expected no byte", rx_count, u_if.tx_data);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (u_if.tx_data !== e) begin
            errors++;
            $display("FAIL tx_byte[%0d]: got %h expected %h", rx_count, u_if.tx_data, e);
          end
        end
        rx_count++;
      end
      prev_stall = u_if.tx_valid && !u_if.tx_ready;
      prev_data = u_if.tx_data;
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    i_arm = 1'b0;
    running = 1'b0;
    step();
    step();
    chk("rst_valid", {31'b0, u_if.tx_valid}, 32'd0);
    chk("rst_halt", {31'b0, cpu_halt}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_timeout", {31'b0, timeout}, 32'd0);
    chk("rst_reg_sel", {27'b0, reg_sel}, 32'd0);
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic start_case(input int bp, input int pct, input bit tmo);
    int base;
    do_reset();
    ready_pct = pct;
    for (int r = 0; r < 32; r++) rf[r] = $urandom();
    rf[0] = 32'hFFFF_FFFF;
    rf[5] = 32'h1234_5678;
    if (tmo) push_record(1'b1, prog_pc(MAX - 1, -1), 32'(MAX));
    else push_record(1'b0, BP, instr_of(BP));
    bp_k = bp;
    i_arm = 1'b1;
    step();
    i_arm = 1'b0;
    running = 1'b1;
    run_k = 0;
    drive_pc();
    if (!tmo) begin
      repeat (bp) step();
      chk("halt_before_match", {31'b0, cpu_halt}, 32'd0);
      step();
      chk("halt_after_match", {31'b0, cpu_halt}, 32'd1);
    end
    base = rx_count;
  endtask

  task automatic run_case(input string nm, input int bp, input int pct, input bit tmo);
    int base;
    start_case(bp, pct, tmo);
    base = rx_count - ((tmo) ? 0 : 0);
    for (int i = 0; i < 5000 && !done; i++) step();
    chk({nm, "_done"}, {31'b0, done}, 32'd1);
    step();
    chk({nm, "_timeout"}, {31'b0, timeout}, {31'b0, tmo});
    chk({nm, "_halt"}, {31'b0, cpu_halt}, {31'b0, !tmo});
    chk({nm, "_left"}, 32'(exp_q.size()), 32'd0);
    chk({nm, "_len"}, 32'(rx_count - base) + ((tmo) ? 32'd0 : 32'd0),
        (tmo) ? 32'(REC_LEN_TMO) : 32'(REC_LEN_BP));
    running = 1'b0;
  endtask

  initial begin
    u_if.tx_ready = 1'b1;
    for (int r = 0; r < 32; r++) rf[r] = 32'h0;
    run_case("bp_ready", 30, 100, 1'b0);
    run_case("bp_stall", 30, 30, 1'b0);
    run_case("tmo", -1, 100, 1'b1);
    run_case("bp_vs_budget", MAX - 1, 60, 1'b0);
    begin : mid_reset
      int base;
      start_case(30, 100, 1'b0);
      base = rx_count;
      for (int i = 0; i < 2000 && (rx_count - base) < 60; i++) step();
      chk("mid_bytes", 32'(rx_count - base), 32'd60);
      rst = 1'b1;
      step();
      exp_q.delete();
      chk("mid_valid", {31'b0, u_if.tx_valid}, 32'd0);
      chk("mid_halt", {31'b0, cpu_halt}, 32'd0);
      chk("mid_done", {31'b0, done}, 32'd0);
      rst = 1'b0;
      running = 1'b0;
    end
    run_case("rearm", 30, 100, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
